flanger_stereo_core: RTL and testbench
======================================

# flanger_stereo_core

Parametrised stereo flanger for the codec audio path: accepts one left/right sample pair per strobe, delays it through a shared circular buffer whose tap is swept by an internal triangle LFO, and adds a slider-scaled wet copy (optionally with feedback) to the dry signal. It sits between the codec receive interface and the transmit interface, in the same slot as the mono flanger, and drives both channels.

## Interface
- DATA_W, 16, signed sample width per channel
- DEPTH_LOG2, 7, log2 of delay-buffer depth in samples (128)
- CTRL_W, 12, unsigned slider width
- LFO_W, 17, LFO phase accumulator width; must be ≥ DEPTH_LOG2+2
- Reset: one clock; reset is synchronous and active-high (ports `clk`, `rst`).
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  one-cycle strobe; left_in/right_in valid this cycle
- left_in, right_in  in  DATA_W  signed input samples
- depth_slider  in  CTRL_W  sweep depth, 0 = fixed 1-sample delay
- rate_slider  in  CTRL_W  LFO phase increment minus one, per sample
- mix_slider  in  CTRL_W  wet gain, value/2^CTRL_W
- fb_en  in  1  feedback mode enable, sampled at capture
- out_valid  out  1  one-cycle strobe; outputs updated this cycle
- left_out, right_out  out  DATA_W  signed processed samples, held between strobes
- busy  out  1  high while a sample is in flight
- overrun  out  1  one-cycle pulse when in_valid arrives while busy

## Operation
- FSM: IDLE → RD → MIX → WR → OUT → IDLE. in_valid accepted only in IDLE; captures left_in, right_in, sliders, fb_en.
- Buffer: 2^DEPTH_LOG2 words of 2·DATA_W ({L,R}), single-port-per-cycle usage, synchronous read, not reset.
- LFO: phase (LFO_W) advances by rate_slider+1 once per processed sample (in WR), wraps modulo 2^LFO_W. tri = phase[LFO_W-2 -: DEPTH_LOG2], inverted bitwise when phase MSB = 1.
- delay = 1 + ((tri · depth_slider) >> CTRL_W); range 1 … 2^DEPTH_LOG2−1, never 0.
- RD: read address = wr_ptr − delay (modulo depth).
- MIX: wet_x = (delayed_x · {0,mix_slider}) >>> CTRL_W, signed arithmetic; wet_x forced to 0 while filled = 0.
- WR: out_x = sat(in_x + wet_x); written_x = fb_en & filled ? sat(in_x + (delayed_x >>> 1)) : in_x; write {L,R} at wr_ptr; wr_ptr++.
- sat(): compute at DATA_W+1 bits, clamp to 0x7FFF / 0x8000 (for DATA_W=16).
- filled: set when wr_ptr wraps 2^DEPTH_LOG2−1 → 0; stays set until reset.
- in_valid while busy: sample dropped, overrun pulses that cycle, no state/pointer change.

## Timing
- Reset values: left_out = right_out = 0, out_valid = 0, busy = 0, overrun = 0; wr_ptr = 0, phase = 0, filled = 0, state IDLE.
- in_valid at cycle C → busy high C+1..C+4 → out_valid high exactly at C+4, left_out/right_out valid same cycle.
- Back-to-back: next in_valid accepted earliest at C+5 (IDLE); strobe at C+1..C+4 → overrun.
- rst in any state: next cycle all reset values; in-flight sample discarded, no write.
- Slider changes mid-flight have no effect on the captured sample.

## Structure
- Package flanger_pkg: state enum, sat() function, default width constants.
- Sub-module flanger_lfo: phase accumulator, triangle fold, depth scaling → delay; enabled by WR step.
- Buffer inferred as RAM in the core.

## Test plan
- mix=0, fb_en=0, in_valid with L=0x1234, R=0xF00D → out_valid 4 cycles later, left_out=0x1234, right_out=0xF00D, busy high 4 cycles.
- mix=0xFFF, first 128 samples of 0x1000 → all outputs 0x1000 (wet suppressed until filled).
- After 128 zero samples, depth=0, mix=0xFFF: impulse L=0x4000 then zeros → next output L=0x3FFC, then 0; with fb_en=1 second echo L=0x1FFE.
- After fill, constant L=0x7FFF, R=0x8000, mix=0xFFF, depth=0 → left_out=0x7FFF, right_out=0x8000 (saturated).
- in_valid at C and C+2 → one out_valid at C+4, overrun pulse at C+2, wr_ptr advanced by 1.
- rst asserted in MIX → next cycle outputs 0, busy 0, no out_valid, filled=0; next in_valid processes normally.

Source files
------------

// File: rtl/flanger_pkg.sv
// Shared types, default widths and the saturation helper for the stereo flanger.
package flanger_pkg;

    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned DEPTH_LOG2_DEF = 7;
    localparam int unsigned CTRL_W_DEF     = 12;
    localparam int unsigned LFO_W_DEF      = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MIX,
        ST_WR,
        ST_OUT
    } state_e;

    // Clamp a wide signed value into the range of a w-bit signed sample.
    function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/flanger_stereo_core_if.sv
// Sample-stream bundle between the codec path and the flanger core.
interface flanger_stereo_core_if
    import flanger_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic                     in_valid;
    logic signed [DATA_W-1:0] left_in;
    logic signed [DATA_W-1:0] right_in;
    logic                     out_valid;
    logic signed [DATA_W-1:0] left_out;
    logic signed [DATA_W-1:0] right_out;
    logic                     busy;
    logic                     overrun;

    modport master (
        output in_valid, left_in, right_in,
        input  out_valid, left_out, right_out, busy, overrun
    );

    modport slave (
        input  in_valid, left_in, right_in,
        output out_valid, left_out, right_out, busy, overrun
    );

endinterface

// File: rtl/flanger_lfo.sv
// Triangle LFO: phase accumulator folded into a triangle and scaled by depth into a tap delay.
module flanger_lfo
    import flanger_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned LFO_W      = LFO_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_i,
    input  logic [CTRL_W-1:0]     rate_i,
    input  logic [CTRL_W-1:0]     depth_i,
    output logic [DEPTH_LOG2-1:0] delay_o
);

    logic [LFO_W-1:0]             phase_q;
    logic [LFO_W-1:0]             phase_d;
    logic [DEPTH_LOG2-1:0]        tri_fold;
    logic [DEPTH_LOG2+CTRL_W-1:0] scaled;

    always_comb begin
        phase_d = phase_q;
        if (step_i) begin
            phase_d = phase_q + LFO_W'(rate_i) + LFO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Falling half of the triangle is the bitwise mirror of the rising half.
    always_comb begin
        tri_fold = phase_q[LFO_W-2 -: DEPTH_LOG2] ^ {DEPTH_LOG2{phase_q[LFO_W-1]}};
        scaled   = (DEPTH_LOG2+CTRL_W)'(tri_fold) * (DEPTH_LOG2+CTRL_W)'(depth_i);
        delay_o  = DEPTH_LOG2'(scaled >> CTRL_W) + DEPTH_LOG2'(1);
    end

endmodule

// File: rtl/flanger_stereo_core.sv
// Stereo flanger: shared {L,R} circular delay buffer tapped by a triangle LFO, wet copy mixed onto dry.
module flanger_stereo_core
    import flanger_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int unsigned CTRL_W     = CTRL_W_DEF,
    parameter int unsigned LFO_W      = LFO_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    flanger_stereo_core_if.slave bus,
    input  logic [CTRL_W-1:0] depth_slider,
    input  logic [CTRL_W-1:0] rate_slider,
    input  logic [CTRL_W-1:0] mix_slider,
    input  logic              fb_en
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    state_e                    state_q;
    logic signed [DATA_W-1:0]  in_l_q, in_r_q, wet_l_q, wet_r_q, out_l_q, out_r_q;
    logic [CTRL_W-1:0]         depth_q, rate_q, mix_q;
    logic                      fb_q, filled_q, busy_q, out_valid_q;
    logic [DEPTH_LOG2-1:0]     wr_ptr_q, delay, rd_addr;
    logic [2*DATA_W-1:0]       mem [DEPTH];
    logic [2*DATA_W-1:0]       rd_q;
    logic signed [DATA_W-1:0]  dly_l, dly_r, wet_l_d, wet_r_d, out_l_d, out_r_d, wr_l_d, wr_r_d;
    logic signed [DATA_W+CTRL_W:0] prod_l, prod_r;

    flanger_lfo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .CTRL_W     (CTRL_W),
        .LFO_W      (LFO_W)
    ) u_lfo (
        .clk     (clk),
        .rst     (rst),
        .step_i  (state_q == ST_WR),
        .rate_i  (rate_q),
        .depth_i (depth_q),
        .delay_o (delay)
    );

    assign rd_addr = wr_ptr_q - delay;
    assign dly_l   = rd_q[2*DATA_W-1:DATA_W];
    assign dly_r   = rd_q[DATA_W-1:0];

    // Mix gain is unsigned, so it is widened with a zero sign bit before the signed multiply.
    always_comb begin
        prod_l  = dly_l * $signed({1'b0, mix_q});
        prod_r  = dly_r * $signed({1'b0, mix_q});
        wet_l_d = filled_q ? DATA_W'(prod_l >>> CTRL_W) : '0;
        wet_r_d = filled_q ? DATA_W'(prod_r >>> CTRL_W) : '0;
        out_l_d = DATA_W'(sat(32'(in_l_q) + 32'(wet_l_q), DATA_W));
        out_r_d = DATA_W'(sat(32'(in_r_q) + 32'(wet_r_q), DATA_W));
        wr_l_d  = in_l_q;
        wr_r_d  = in_r_q;
        if (fb_q && filled_q) begin
            wr_l_d = DATA_W'(sat(32'(in_l_q) + 32'(dly_l >>> 1), DATA_W));
            wr_r_d = DATA_W'(sat(32'(in_r_q) + 32'(dly_r >>> 1), DATA_W));
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_RD) begin
            rd_q <= mem[rd_addr];
        end
        if (!rst && state_q == ST_WR) begin
            mem[wr_ptr_q] <= {wr_l_d, wr_r_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_l_q      <= '0;
            in_r_q      <= '0;
            wet_l_q     <= '0;
            wet_r_q     <= '0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            depth_q     <= '0;
            rate_q      <= '0;
            mix_q       <= '0;
            fb_q        <= 1'b0;
            filled_q    <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        in_l_q  <= bus.left_in;
                        in_r_q  <= bus.right_in;
                        depth_q <= depth_slider;
                        rate_q  <= rate_slider;
                        mix_q   <= mix_slider;
                        fb_q    <= fb_en;
                        busy_q  <= 1'b1;
                        state_q <= ST_RD;
                    end
                end
                ST_RD:  state_q <= ST_MIX;
                ST_MIX: begin
                    wet_l_q <= wet_l_d;
                    wet_r_q <= wet_r_d;
                    state_q <= ST_WR;
                end
                ST_WR: begin
                    out_l_q     <= out_l_d;
                    out_r_q     <= out_r_d;
                    out_valid_q <= 1'b1;
                    wr_ptr_q    <= wr_ptr_q + DEPTH_LOG2'(1);
                    if (wr_ptr_q == '1) begin
                        filled_q <= 1'b1;
                    end
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.left_out  = out_l_q;
    assign bus.right_out = out_r_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = bus.in_valid && busy_q;

endmodule

// File: tb/tb_flanger_stereo_core.sv
// Scoreboard bench for flanger_stereo_core: a behavioural model predicts each output pair.
module tb_flanger_stereo_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] depth, rate, mix;
    logic        fb;

    always #5 clk = ~clk;

    flanger_stereo_core_if #(.DATA_W(16)) bus ();

    flanger_stereo_core #(
        .DATA_W     (16),
        .DEPTH_LOG2 (7),
        .CTRL_W     (12),
        .LFO_W      (17)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .depth_slider (depth),
        .rate_slider  (rate),
        .mix_slider   (mix),
        .fb_en        (fb)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    int mbl[128];
    int mbr[128];
    int m_wr, m_phase;
    bit m_filled;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        m_wr = 0;
        m_phase = 0;
        m_filled = 0;
    endtask

    task automatic model_push(input logic [15:0] lv, input logic [15:0] rv, input int mx,
                              input int dp, input int rt, input bit f);
        int l, r, t, d, rd, dl, dr, wl, wr_, ol, orr;
        logic [15:0] ol16, or16;
        l = int'($signed(lv));
        r = int'($signed(rv));
        t = (m_phase >> 9) & 127;
        if (((m_phase >> 16) & 1) == 1) t = t ^ 127;
        d  = 1 + ((t * dp) >> 12);
        rd = (m_wr - d) & 127;
        dl = mbl[rd];
        dr = mbr[rd];
        ol  = sat16(l + (m_filled ? ((dl * mx) >>> 12) : 0));
        orr = sat16(r + (m_filled ? ((dr * mx) >>> 12) : 0));
        wl  = (f && m_filled) ? sat16(l + (dl >>> 1)) : l;
        wr_ = (f && m_filled) ? sat16(r + (dr >>> 1)) : r;
        mbl[m_wr] = wl;
        mbr[m_wr] = wr_;
        if (m_wr == 127) m_filled = 1;
        m_wr = (m_wr + 1) & 127;
        m_phase = (m_phase + rt + 1) & 'h1FFFF;
        ol16 = 16'(ol);
        or16 = 16'(orr);
        exp_q.push_back({ol16, or16});
    endtask

    // Sliders are scrambled right after the strobe: only the captured values may matter.
    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [11:0] mx,
                        input logic [11:0] dp, input logic [11:0] rt, input logic f);
        @(negedge clk);
        bus.left_in  = l;
        bus.right_in = r;
        mix = mx; depth = dp; rate = rt; fb = f;
        bus.in_valid = 1'b1;
        model_push(l, r, int'(mx), int'(dp), int'(rt), f);
        #1 check("overrun_idle", {31'b0, bus.overrun}, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.left_in  = 16'($urandom());
        bus.right_in = 16'($urandom());
        mix   = 12'($urandom());
        depth = 12'($urandom());
        rate  = 12'($urandom());
        fb    = 1'($urandom());
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", {31'b0, bus.out_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("left_out", {16'b0, bus.left_out}, {16'b0, mon_e[31:16]});
                check("right_out", {16'b0, bus.right_out}, {16'b0, mon_e[15:0]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mbl[i] = 0;
            mbr[i] = 0;
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.left_in = '0;
        bus.right_in = '0;
        mix = '0; depth = '0; rate = '0; fb = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_left_out", {16'b0, bus.left_out}, 32'd0);
        check("rst_right_out", {16'b0, bus.right_out}, 32'd0);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_overrun", {31'b0, bus.overrun}, 32'd0);
        rst = 1'b0;

        // Latency and busy window for a single sample with dry-only mix.
        @(negedge clk);
        bus.left_in = 16'h1234; bus.right_in = 16'hF00D;
        mix = '0; depth = '0; rate = '0; fb = 1'b0;
        bus.in_valid = 1'b1;
        model_push(16'h1234, 16'hF00D, 0, 0, 0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) bus.in_valid = 1'b0;
            check("busy_window", {31'b0, bus.busy}, {31'b0, (i <= 4)});
            check("out_valid_timing", {31'b0, bus.out_valid}, {31'b0, (i == 4)});
            if (i == 4) begin
                check("t1_left", {16'b0, bus.left_out}, 32'h1234);
                check("t1_right", {16'b0, bus.right_out}, 32'h0000F00D);
            end
        end

        // Wet path suppressed until the buffer has wrapped once.
        do_reset();
        for (int i = 0; i < 128; i++) send(16'h1000, 16'h1000, 12'hFFF, 12'h000, 12'($urandom()), 1'b0);
        for (int i = 0; i < 128; i++) send(16'h0000, 16'h0000, 12'hFFF, 12'h000, 12'($urandom()), 1'b0);

        // Impulse echoes, without then with feedback.
        send(16'h4000, 16'h0000, 12'hFFF, 12'h000, 12'h010, 1'b0);
        for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000, 12'hFFF, 12'h000, 12'h010, 1'b0);
        send(16'h4000, 16'hC000, 12'hFFF, 12'h000, 12'h010, 1'b1);
        for (int i = 0; i < 4; i++) send(16'h0000, 16'h0000, 12'hFFF, 12'h000, 12'h010, 1'b1);

        // Saturation at both rails.
        for (int i = 0; i < 8; i++) send(16'h7FFF, 16'h8000, 12'hFFF, 12'h000, 12'h020, 1'b0);

        // Overrun: second strobe two cycles in is dropped.
        @(negedge clk);
        bus.left_in = 16'h0ABC; bus.right_in = 16'h0DEF;
        mix = 12'h800; depth = '0; rate = 12'h005; fb = 1'b0;
        bus.in_valid = 1'b1;
        model_push(16'h0ABC, 16'h0DEF, 'h800, 0, 5, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.left_in = 16'h5555; bus.right_in = 16'h6666;
        bus.in_valid = 1'b1;
        #1 check("overrun_pulse", {31'b0, bus.overrun}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 check("overrun_clear", {31'b0, bus.overrun}, 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) send(16'($urandom()), 16'($urandom()), 12'hFFF, 12'h000, 12'h003, 1'b0);

        // Swept tap with random material, gains and feedback.
        for (int i = 0; i < 200; i++) begin
            send(16'($urandom()), 16'($urandom()), 12'($urandom_range(0, 4095)),
                 (i < 100) ? 12'hFFF : 12'($urandom_range(0, 4095)),
                 12'($urandom_range(1024, 4095)), 1'($urandom_range(0, 1)));
        end

        // Reset while the sample is in MIX.
        @(negedge clk);
        bus.left_in = 16'h2222; bus.right_in = 16'h3333;
        mix = 12'hFFF; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("mixrst_busy", {31'b0, bus.busy}, 32'd0);
        check("mixrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mixrst_left", {16'b0, bus.left_out}, 32'd0);
        check("mixrst_right", {16'b0, bus.right_out}, 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) send(16'h0100, 16'hFF00, 12'hFFF, 12'h000, 12'h001, 1'b1);

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
